// File: rtl/branch_resolver_seq_pkg.sv
// Shared definitions for the multi-cycle branch resolver: FSM states,
// RV32 branch funct3 codes and the funct3-to-taken decode.
package branch_resolver_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 010/011 are not branch encodings; they resolve but never take.
    function automatic logic is_illegal(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       eq,
                                          input logic       lt);
        logic t;
        case (f3)
            F3_BEQ:  t = eq;
            F3_BNE:  t = !eq;
            F3_BLT:  t = lt;
            F3_BGE:  t = !lt;
            F3_BLTU: t = lt;
            F3_BGEU: t = !lt;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_resolver_seq_comparatorX8.sv
// One-byte magnitude comparator; sign_i selects two's-complement ordering
// so the top byte of a signed operand compares correctly.
module comparatorX8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       sign_i,
    output logic       eq_o,
    output logic       gt_o,
    output logic       lt_o
);

    // Equality is sign-agnostic; ordering depends on sign_i.
    always_comb begin
        eq_o = (a_i == b_i);
        if (sign_i) begin
            gt_o = ($signed(a_i) > $signed(b_i));
            lt_o = ($signed(a_i) < $signed(b_i));
        end else begin
            gt_o = (a_i > b_i);
            lt_o = (a_i < b_i);
        end
    end

endmodule

// File: rtl/branch_resolver_seq.sv
// Branch-condition resolver: scans two operands MSB byte first through a
// single byte comparator, stopping at the first differing byte.
module branch_resolver_seq
    import branch_resolver_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             illegal
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] rs1_q, rs1_d;
    logic [WIDTH-1:0] rs2_q, rs2_d;
    logic [2:0]       f3_q, f3_d;
    logic             taken_q, taken_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             illegal_q, illegal_d;

    logic [7:0] a_byte_s;
    logic [7:0] b_byte_s;
    logic       sign_s;
    logic       cmp_eq_s;
    logic       cmp_gt_s;
    logic       cmp_lt_s;

    // Only the top byte carries the sign, and only for BLT/BGE.
    always_comb begin
        a_byte_s = rs1_q[idx_q*8 +: 8];
        b_byte_s = rs2_q[idx_q*8 +: 8];
        sign_s   = (idx_q == IDX_TOP) && (f3_q[2:1] == 2'b10);
    end

    comparatorX8 u_cmp (
        .a_i    (a_byte_s),
        .b_i    (b_byte_s),
        .sign_i (sign_s),
        .eq_o   (cmp_eq_s),
        .gt_o   (cmp_gt_s),
        .lt_o   (cmp_lt_s)
    );

    // Next-state and result capture.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        f3_d      = f3_q;
        taken_d   = taken_q;
        eq_d      = eq_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rs1_d   = rs1;
                    rs2_d   = rs2;
                    f3_d    = funct3;
                    idx_d   = IDX_TOP;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!cmp_eq_s || (idx_q == IDX_ZERO)) begin
                    eq_d      = cmp_eq_s;
                    gt_d      = cmp_gt_s;
                    lt_d      = cmp_lt_s;
                    illegal_d = is_illegal(f3_q);
                    taken_d   = branch_taken(f3_q, cmp_eq_s, cmp_lt_s);
                    state_d   = ST_DONE;
                end else begin
                    idx_d     = idx_q - IDX_ONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= IDX_TOP;
            rs1_q     <= {WIDTH{1'b0}};
            rs2_q     <= {WIDTH{1'b0}};
            f3_q      <= 3'b000;
            taken_q   <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            f3_q      <= f3_d;
            taken_q   <= taken_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign taken     = taken_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign lt        = lt_q;
    assign illegal   = illegal_q;

endmodule
